// File: rtl/usb2_pkg.sv
// Shared definitions for the USB2 transfer initiator:
// PID codes, state encodings and the default packet size.
package usb2_pkg;

  localparam int MAX_PKT_DEF = 512;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_e;

  typedef enum logic [2:0] {
    IDLE,
    RX_DATA,
    RX_HS,
    TX_CHK,
    TX_DATA,
    TX_WAIT_HS,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SQ_IDLE,
    SQ_RD0,
    SQ_RD1,
    SQ_SHOW
  } seq_e;

  function automatic logic [3:0] data_pid(input logic tog);
    return tog ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/usb2_tx_seq.sv
// Transmit byte sequencer: walks the endpoint buffer from address 0,
// absorbs the one-cycle read latency and flags the final beat.
module usb2_tx_seq
  import usb2_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [9:0] len_i,
  input  logic [3:0] pid_i,
  input  logic [7:0] rd_q_i,
  input  logic       tx_ready_i,
  output logic [8:0] rd_addr_o,
  output logic       tx_valid_o,
  output logic       tx_last_o,
  output logic [7:0] tx_data_o,
  output logic [3:0] tx_pid_o,
  output logic       done_o
);

  seq_e       st_q;
  logic [9:0] len_q;
  logic [8:0] addr_q;
  logic       valid_q;
  logic       last_q;
  logic       done_q;
  logic [7:0] data_q;
  logic [3:0] pid_q;
  logic       is_last;

  assign is_last = ({1'b0, addr_q} == len_q - 10'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q    <= SQ_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      pid_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        SQ_IDLE: begin
          if (start_i) begin
            len_q  <= len_i;
            addr_q <= '0;
            pid_q  <= pid_i;
            // An empty buffer still produces one terminating beat
            if (len_i == 10'd0) begin
              valid_q <= 1'b1;
              last_q  <= 1'b1;
              data_q  <= '0;
              st_q    <= SQ_SHOW;
            end else begin
              st_q <= SQ_RD0;
            end
          end
        end
        SQ_RD0: st_q <= SQ_RD1;
        SQ_RD1: begin
          data_q  <= rd_q_i;
          valid_q <= 1'b1;
          last_q  <= is_last;
          st_q    <= SQ_SHOW;
        end
        SQ_SHOW: begin
          if (tx_ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (last_q) begin
              done_q <= 1'b1;
              st_q   <= SQ_IDLE;
            end else begin
              addr_q <= addr_q + 9'd1;
              st_q   <= SQ_RD0;
            end
          end
        end
        default: st_q <= SQ_IDLE;
      endcase
    end
  end

  assign rd_addr_o  = addr_q;
  assign tx_valid_o = valid_q;
  assign tx_last_o  = last_q;
  assign tx_data_o  = data_q;
  assign tx_pid_o   = pid_q;
  assign done_o     = done_q;

endmodule

// File: rtl/usb2_xfer_initiator.sv
// USB2 device-side transfer initiator: token filtering, OUT/SETUP
// reception with handshake, IN transmission with per-endpoint toggles.
module usb2_xfer_initiator
  import usb2_pkg::*;
#(
  parameter int MAX_PKT    = MAX_PKT_DEF,
  parameter int HS_TIMEOUT = 255
) (
  input  logic       phy_clk,
  input  logic       reset,
  input  logic       rx_tok_valid,
  input  logic [3:0] rx_tok_pid,
  input  logic [6:0] rx_tok_addr,
  input  logic [3:0] rx_tok_endp,
  input  logic       rx_data_valid,
  input  logic [7:0] rx_data,
  input  logic [3:0] rx_data_pid,
  input  logic       rx_data_end,
  input  logic       rx_crc_ok,
  input  logic       rx_hs_valid,
  input  logic [3:0] rx_hs_pid,
  output logic       tx_hs_req,
  output logic [3:0] tx_hs_pid,
  input  logic       tx_hs_ack,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_last,
  output logic [3:0] tx_pid,
  input  logic       tx_ready,
  output logic       xfer_in,
  output logic       xfer_out,
  output logic [3:0] xfer_endp,
  output logic [3:0] xfer_pid,
  input  logic       xfer_ready,
  output logic [8:0] buf_in_addr,
  output logic [7:0] buf_in_data,
  output logic       buf_in_wren,
  output logic [8:0] buf_out_addr,
  input  logic [7:0] buf_out_q,
  input  logic [9:0] buf_out_len,
  input  logic [6:0] dev_addr
);

  localparam logic [9:0]  MAXP     = 10'(MAX_PKT);
  localparam logic [15:0] TMO_LAST = 16'(HS_TIMEOUT - 1);

  state_e      state_q;
  logic [3:0]  endp_q;
  logic        setup_q;
  logic        first_q;
  logic        ovf_q;
  logic [9:0]  wr_cnt_q;
  logic [15:0] tog_q;
  logic [15:0] tmr_q;
  logic        xin_q;
  logic        xout_q;
  logic [3:0]  xpid_q;
  logic        hs_req_q;
  logic [3:0]  hs_pid_q;
  logic [8:0]  bin_addr_q;
  logic [7:0]  bin_data_q;
  logic        bin_wren_q;

  logic       tok_hit;
  logic       tok_rx;
  logic       room;
  logic       ovf_now;
  logic       seq_start;
  logic       seq_done;
  logic [9:0] seq_len;

  assign tok_hit   = rx_tok_valid && (rx_tok_addr == dev_addr);
  assign tok_rx    = (rx_tok_pid == PID_OUT) || (rx_tok_pid == PID_SETUP);
  assign room      = wr_cnt_q < MAXP;
  assign ovf_now   = ovf_q | (rx_data_valid & ~room);
  assign seq_start = (state_q == TX_CHK) && xfer_ready;
  assign seq_len   = (buf_out_len > MAXP) ? MAXP : buf_out_len;

  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      endp_q     <= '0;
      setup_q    <= 1'b0;
      first_q    <= 1'b0;
      ovf_q      <= 1'b0;
      wr_cnt_q   <= '0;
      tog_q      <= '0;
      tmr_q      <= '0;
      xin_q      <= 1'b0;
      xout_q     <= 1'b0;
      xpid_q     <= '0;
      hs_req_q   <= 1'b0;
      hs_pid_q   <= '0;
      bin_addr_q <= '0;
      bin_data_q <= '0;
      bin_wren_q <= 1'b0;
    end else begin
      bin_wren_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tok_hit && tok_rx) begin
            endp_q   <= rx_tok_endp;
            setup_q  <= (rx_tok_pid == PID_SETUP);
            first_q  <= 1'b1;
            ovf_q    <= 1'b0;
            wr_cnt_q <= '0;
            xin_q    <= 1'b1;
            state_q  <= RX_DATA;
          end else if (tok_hit && rx_tok_pid == PID_IN) begin
            endp_q  <= rx_tok_endp;
            state_q <= TX_CHK;
          end
        end
        RX_DATA: begin
          if (rx_data_valid) begin
            first_q <= 1'b0;
            if (first_q)
              xpid_q <= setup_q ? PID_SETUP : rx_data_pid;
            if (room) begin
              bin_wren_q <= 1'b1;
              bin_addr_q <= wr_cnt_q[8:0];
              bin_data_q <= rx_data;
              wr_cnt_q   <= wr_cnt_q + 10'd1;
            end else begin
              ovf_q <= 1'b1;
            end
          end
          if (rx_data_end) begin
            if (rx_crc_ok && setup_q)
              tog_q[endp_q] <= 1'b1;
            if (rx_crc_ok && !ovf_now) begin
              hs_req_q <= 1'b1;
              hs_pid_q <= (setup_q || xfer_ready) ? PID_ACK : PID_NAK;
              state_q  <= RX_HS;
            end else begin
              xin_q   <= 1'b0;
              state_q <= DONE;
            end
          end
        end
        RX_HS: begin
          if (tx_hs_ack) begin
            hs_req_q <= 1'b0;
            xin_q    <= 1'b0;
            xout_q   <= 1'b0;
            state_q  <= DONE;
          end
        end
        TX_CHK: begin
          if (!xfer_ready) begin
            hs_req_q <= 1'b1;
            hs_pid_q <= PID_NAK;
            state_q  <= RX_HS;
          end else begin
            xout_q  <= 1'b1;
            xpid_q  <= data_pid(tog_q[endp_q]);
            state_q <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (seq_done) begin
            tmr_q   <= '0;
            state_q <= TX_WAIT_HS;
          end
        end
        TX_WAIT_HS: begin
          // Only a host ACK confirms delivery and advances the toggle
          if (rx_hs_valid) begin
            if (rx_hs_pid == PID_ACK)
              tog_q[endp_q] <= ~tog_q[endp_q];
            xout_q  <= 1'b0;
            state_q <= DONE;
          end else if (tmr_q == TMO_LAST) begin
            xout_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            tmr_q <= tmr_q + 16'd1;
          end
        end
        DONE: begin
          xin_q   <= 1'b0;
          xout_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  usb2_tx_seq u_tx_seq (
    .clk_i      (phy_clk),
    .rst_i      (reset),
    .start_i    (seq_start),
    .len_i      (seq_len),
    .pid_i      (data_pid(tog_q[endp_q])),
    .rd_q_i     (buf_out_q),
    .tx_ready_i (tx_ready),
    .rd_addr_o  (buf_out_addr),
    .tx_valid_o (tx_valid),
    .tx_last_o  (tx_last),
    .tx_data_o  (tx_data),
    .tx_pid_o   (tx_pid),
    .done_o     (seq_done)
  );

  assign tx_hs_req   = hs_req_q;
  assign tx_hs_pid   = hs_pid_q;
  assign xfer_in     = xin_q;
  assign xfer_out    = xout_q;
  assign xfer_endp   = endp_q;
  assign xfer_pid    = xpid_q;
  assign buf_in_addr = bin_addr_q;
  assign buf_in_data = bin_data_q;
  assign buf_in_wren = bin_wren_q;

endmodule

// File: tb/tb_usb2_xfer_initiator.sv
// Scoreboard bench for usb2_xfer_initiator: directed scenarios plus
// randomized OUT/SETUP/IN traffic against a transaction-level model.
module tb_usb2_xfer_initiator;

  localparam int MAXP = 512;
  localparam int HST  = 255;
  localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001;
  localparam logic [3:0] P_SETUP = 4'b1101, P_D0 = 4'b0011;
  localparam logic [3:0] P_D1 = 4'b1011, P_ACK = 4'b0010;
  localparam logic [3:0] P_NAK = 4'b1010, P_STALL = 4'b1110;

  logic       phy_clk = 0, reset = 0;
  logic       rx_tok_valid = 0;
  logic [3:0] rx_tok_pid = 0, rx_tok_endp = 0;
  logic [6:0] rx_tok_addr = 0, dev_addr = 0;
  logic       rx_data_valid = 0, rx_data_end = 0, rx_crc_ok = 0;
  logic [7:0] rx_data = 0;
  logic [3:0] rx_data_pid = 0;
  logic       rx_hs_valid = 0;
  logic [3:0] rx_hs_pid = 0;
  logic       tx_hs_req, tx_hs_ack = 0;
  logic [3:0] tx_hs_pid, tx_pid, xfer_endp, xfer_pid;
  logic       tx_valid, tx_last, tx_ready = 0;
  logic [7:0] tx_data, buf_in_data, buf_out_q = 0;
  logic       xfer_in, xfer_out, xfer_ready = 0, buf_in_wren;
  logic [8:0] buf_in_addr, buf_out_addr;
  logic [9:0] buf_out_len = 0;

  always #5 phy_clk = ~phy_clk;

  usb2_xfer_initiator dut (
    .phy_clk(phy_clk), .reset(reset),
    .rx_tok_valid(rx_tok_valid), .rx_tok_pid(rx_tok_pid),
    .rx_tok_addr(rx_tok_addr), .rx_tok_endp(rx_tok_endp),
    .rx_data_valid(rx_data_valid), .rx_data(rx_data),
    .rx_data_pid(rx_data_pid), .rx_data_end(rx_data_end),
    .rx_crc_ok(rx_crc_ok), .rx_hs_valid(rx_hs_valid),
    .rx_hs_pid(rx_hs_pid), .tx_hs_req(tx_hs_req),
    .tx_hs_pid(tx_hs_pid), .tx_hs_ack(tx_hs_ack),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_pid(tx_pid), .tx_ready(tx_ready), .xfer_in(xfer_in),
    .xfer_out(xfer_out), .xfer_endp(xfer_endp),
    .xfer_pid(xfer_pid), .xfer_ready(xfer_ready),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data),
    .buf_in_wren(buf_in_wren), .buf_out_addr(buf_out_addr),
    .buf_out_q(buf_out_q), .buf_out_len(buf_out_len),
    .dev_addr(dev_addr)
  );

  // Endpoint transmit buffer with one-cycle read latency
  logic [7:0] omem [512];
  always @(posedge phy_clk) buf_out_q <= omem[buf_out_addr];

  typedef struct {
    logic [3:0] pid;
    logic       chk_x;
    logic [3:0] xpid;
  } hs_t;
  typedef struct {
    logic [7:0] d;
    logic       last;
    logic [3:0] pid;
    logic       zlp;
  } tx_t;

  logic [16:0] exp_wr[$];
  hs_t         exp_hs[$];
  tx_t         exp_tx[$];
  logic [3:0]  exp_xin[$];
  logic [3:0]  exp_xout[$];
  logic [15:0] tog_m = '0;

  int n_chk = 0, n_pass = 0;
  int rmode = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  function automatic logic [63:0] all_outs();
    return {tx_hs_req, tx_hs_pid, tx_valid, tx_data, tx_last,
            tx_pid, xfer_in, xfer_out, xfer_endp, xfer_pid,
            buf_in_addr, buf_in_data, buf_in_wren, buf_out_addr};
  endfunction

  // ---- monitors ----
  logic [16:0] mw;
  always @(negedge phy_clk) if (!reset && buf_in_wren) begin
    check("wr_pending", 64'(exp_wr.size() != 0), 1);
    if (exp_wr.size() != 0) begin
      mw = exp_wr.pop_front();
      check("buf_wr", {buf_in_addr, buf_in_data}, mw);
    end
  end

  hs_t mh;
  always @(negedge phy_clk) begin
    if (!reset && tx_hs_req && !tx_hs_ack) begin
      check("hs_pending", 64'(exp_hs.size() != 0), 1);
      if (exp_hs.size() != 0) begin
        mh = exp_hs.pop_front();
        check("hs_pid", tx_hs_pid, mh.pid);
        if (mh.chk_x) check("xfer_pid", xfer_pid, mh.xpid);
      end
      tx_hs_ack = 1;
    end else begin
      tx_hs_ack = 0;
    end
  end

  tx_t mt;
  always @(negedge phy_clk) if (!reset && tx_valid && tx_ready) begin
    check("tx_pending", 64'(exp_tx.size() != 0), 1);
    if (exp_tx.size() != 0) begin
      mt = exp_tx.pop_front();
      check("tx_pid", tx_pid, mt.pid);
      check("tx_last", tx_last, mt.last);
      if (!mt.zlp) check("tx_data", tx_data, mt.d);
    end
  end

  logic xin_p = 0, xout_p = 0;
  logic [3:0] me;
  always @(negedge phy_clk) begin
    if (reset) begin
      xin_p = 0;
      xout_p = 0;
    end else begin
      if (xfer_in && !xin_p) begin
        check("xin_pending", 64'(exp_xin.size() != 0), 1);
        if (exp_xin.size() != 0) begin
          me = exp_xin.pop_front();
          check("xin_endp", xfer_endp, me);
        end
      end
      if (xfer_out && !xout_p) begin
        check("xout_pending", 64'(exp_xout.size() != 0), 1);
        if (exp_xout.size() != 0) begin
          me = exp_xout.pop_front();
          check("xout_endp", xfer_endp, me);
        end
      end
      xin_p = xfer_in;
      xout_p = xfer_out;
    end
  end

  initial begin
    forever begin
      @(posedge phy_clk);
      #1;
      case (rmode)
        0: tx_ready = 1;
        1: tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---- stimulus ----
  task automatic tick(int n = 1);
    repeat (n) @(posedge phy_clk);
    #1;
  endtask

  task automatic send_tok(logic [3:0] pid, logic [6:0] a, logic [3:0] ep);
    rx_tok_valid = 1;
    rx_tok_pid = pid;
    rx_tok_addr = a;
    rx_tok_endp = ep;
    tick();
    rx_tok_valid = 0;
  endtask

  task automatic send_pkt(logic [3:0] tok, logic [6:0] a, logic [3:0] ep,
                          logic [3:0] dpid, input logic [7:0] b[$],
                          logic crc);
    send_tok(tok, a, ep);
    foreach (b[i]) begin
      rx_data_valid = 1;
      rx_data = b[i];
      rx_data_pid = dpid;
      tick();
    end
    rx_data_valid = 0;
    rx_data_end = 1;
    rx_crc_ok = crc;
    tick();
    rx_data_end = 0;
    rx_crc_ok = 0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_hs.size() != 0 || exp_wr.size() != 0) && k < 300) begin
      tick();
      k++;
    end
    check("hs_drain", exp_hs.size(), 0);
    check("wr_drain", exp_wr.size(), 0);
    tick(4);
  endtask

  task automatic do_out(logic [3:0] tok, logic [3:0] ep, logic [3:0] dpid,
                        int n, logic crc, logic rdy);
    logic [7:0] b[$];
    logic [7:0] v;
    xfer_ready = rdy;
    exp_xin.push_back(ep);
    for (int i = 0; i < n; i++) begin
      v = 8'($urandom);
      b.push_back(v);
      if (i < MAXP) exp_wr.push_back({9'(i), v});
    end
    if (crc && n <= MAXP)
      exp_hs.push_back('{pid: (tok == P_SETUP || rdy) ? P_ACK : P_NAK,
                         chk_x: 1,
                         xpid: (tok == P_SETUP) ? P_SETUP : dpid});
    if (crc && tok == P_SETUP) tog_m[ep] = 1;
    send_pkt(tok, dev_addr, ep, dpid, b, crc);
    drain();
  endtask

  // hs: 0 = host silent, 1 = ACK, 2 = NAK, 3 = STALL
  task automatic do_in(logic [3:0] ep, int len, logic rdy, int hs);
    int n = (len > MAXP) ? MAXP : len;
    int k = 0;
    logic [3:0] p = tog_m[ep] ? P_D1 : P_D0;
    buf_out_len = 10'(len);
    xfer_ready = rdy;
    if (!rdy) begin
      exp_hs.push_back('{pid: P_NAK, chk_x: 0, xpid: 0});
    end else begin
      exp_xout.push_back(ep);
      if (n == 0) exp_tx.push_back('{d: 0, last: 1, pid: p, zlp: 1});
      for (int i = 0; i < n; i++)
        exp_tx.push_back('{d: omem[i], last: (i == n - 1), pid: p, zlp: 0});
    end
    send_tok(P_IN, dev_addr, ep);
    if (!rdy) begin
      drain();
    end else begin
      while (exp_tx.size() != 0 && k < 8000) begin
        tick();
        k++;
      end
      check("tx_drain", exp_tx.size(), 0);
      tick(3);
      if (hs == 0) begin
        // a token while the handshake is pending must be dropped
        send_tok(P_OUT, dev_addr, 4'd1);
        tick(HST + 8);
      end else begin
        rx_hs_valid = 1;
        rx_hs_pid = (hs == 1) ? P_ACK : (hs == 2) ? P_NAK : P_STALL;
        tick();
        rx_hs_valid = 0;
        if (hs == 1) tog_m[ep] = ~tog_m[ep];
        tick(4);
      end
    end
  endtask

  initial begin
    logic [7:0] fb[$];
    int k;
    for (int i = 0; i < 512; i++) omem[i] = 8'($urandom);
    #2 reset = 1;
    #2 check("reset_outputs", all_outs(), 0);
    repeat (3) @(posedge phy_clk);
    #1 reset = 0;
    tick(2);
    check("idle_outputs", all_outs(), 0);

    dev_addr = 7'd0;
    do_out(P_SETUP, 0, P_D0, 8, 1, 0);
    do_out(P_OUT, 0, P_D1, 3, 1, 0);
    do_out(P_OUT, 0, P_D1, 3, 1, 1);
    rmode = 1;
    do_in(0, 18, 1, 1);
    rmode = 0;
    do_in(0, 0, 1, 0);
    do_in(0, 5, 1, 2);
    do_in(0, 4, 1, 1);

    dev_addr = 7'd3;
    do_out(P_OUT, 1, P_D0, 6, 0, 1);
    for (int i = 0; i < 4; i++) fb.push_back(8'(i + 1));
    send_pkt(P_OUT, 7'd5, 4'd2, P_D0, fb, 1);
    send_tok(P_IN, 7'd5, 4'd2);
    tick(10);

    do_out(P_OUT, 2, P_D0, MAXP, 1, 1);
    do_out(P_OUT, 2, P_D0, MAXP + 2, 1, 1);
    do_in(1, 600, 1, 1);
    do_in(3, 10, 0, 0);

    for (int t = 0; t < 30; t++) begin
      logic [3:0] ep = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: do_out(P_OUT, ep, $urandom_range(0, 1) ? P_D1 : P_D0,
                  $urandom_range(1, 24), $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)));
        1: do_out(P_SETUP, ep, P_D0, 8, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)));
        default: begin
          rmode = $urandom_range(0, 2);
          do_in(ep, $urandom_range(0, 40), $urandom_range(0, 3) != 0,
                (t == 7) ? 0 : $urandom_range(1, 3));
        end
      endcase
    end

    // abort in the middle of an IN data stage
    rmode = 1;
    do_out(P_SETUP, 2, P_D0, 8, 1, 1);
    buf_out_len = 10'd40;
    xfer_ready = 1;
    exp_xout.push_back(4'd2);
    for (int i = 0; i < 40; i++)
      exp_tx.push_back('{d: omem[i], last: (i == 39), pid: P_D1, zlp: 0});
    send_tok(P_IN, dev_addr, 4'd2);
    k = 0;
    while (exp_tx.size() > 34 && k < 2000) begin
      tick();
      k++;
    end
    check("pre_abort_beats", exp_tx.size(), 34);
    #2 reset = 1;
    #1 check("abort_outputs", all_outs(), 0);
    exp_tx.delete();
    tog_m = '0;
    tick(2);
    reset = 0;
    tick(2);
    rmode = 0;
    do_in(2, 6, 1, 1);
    do_out(P_OUT, 4, P_D1, 2, 1, 1);

    check("left_wr", exp_wr.size(), 0);
    check("left_hs", exp_hs.size(), 0);
    check("left_tx", exp_tx.size(), 0);
    check("left_xin", exp_xin.size(), 0);
    check("left_xout", exp_xout.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
